mips_multicycle_ctrl: RTL and testbench
=======================================

Name: mips_multicycle_ctrl

Overview:
- Control FSM that sequences the shared multicycle MIPS datapath: one unified instruction/data memory, one ALU, register file, IR and PC.
- Decodes op/funct from the IR and drives mux selects, write enables and ALU control each cycle.
- Holds in memory-access states until the memory reports ready.
- Sits inside the mips core between IR/ALU-flag outputs and datapath control inputs.

Parameters:
- SUPPORT_BNE, 1, when 1 opcode 000101 (bne) is executed; when 0 it is treated as illegal.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- op  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- memready  in  1  memory completes access this cycle
- iord  out  1  memory address select: 0=PC, 1=ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  IR load enable
- regdst  out  1  write register: 0=rt, 1=rd
- memtoreg  out  1  write data: 0=ALUOut, 1=MDR
- regwrite  out  1  register file write enable
- alusrca  out  1  0=PC, 1=rs
- alusrcb  out  2  00=rt, 01=const 4, 10=signimm, 11=signimm<<2
- pcsrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- pcen  out  1  PC load enable
- alucontrol  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- illegal_op  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state, debug

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, RTYPEWB=7, BEQEX=8, ADDIEX=9, ADDIWB=10, JEX=11, BNEEX=12.
- State register is synchronous. reset=1 at a rising edge forces FETCH. This applies mid-instruction; no partial write completes after that edge.
- While reset=1, memwrite, regwrite, irwrite and pcen are forced to 0, combinationally.
- Outputs are a Moore decode of state, except for pcen, irwrite and memwrite gating described below. Any output not listed for a state is 0.
- Outputs per state:
  - FETCH: iord=0, alusrca=0, alusrcb=01, ALU add, pcsrc=00. irwrite=pcwrite=memready. Stay in FETCH while memready=0, else go to DECODE.
  - DECODE: alusrca=0, alusrcb=11, add.
    - Next state by op: 100011/101011→MEMADR, 000000→RTYPEEX, 000100→BEQEX, 000101→BNEEX (if SUPPORT_BNE), 001000→ADDIEX, 000010→JEX.
    - Any other op: illegal_op=1, next state FETCH, no architectural state change.
  - MEMADR: alusrca=1, alusrcb=10, add. op=100011→MEMRD, else MEMWR.
  - MEMRD: iord=1. Hold until memready, then MEMWB.
  - MEMWB: regdst=0, memtoreg=1, regwrite=1. Next FETCH.
  - MEMWR: iord=1, memwrite=1, held constant while waiting. Go to FETCH on memready.
  - RTYPEEX: alusrca=1, alusrcb=00, alucontrol from funct. Next RTYPEWB.
  - RTYPEWB: regdst=1, memtoreg=0, regwrite=1. Next FETCH.
  - BEQEX: alusrca=1, alusrcb=00, sub, pcsrc=01, pcen=zero. Next FETCH.
  - BNEEX: same as BEQEX but pcen=~zero. Next FETCH.
  - ADDIEX: alusrca=1, alusrcb=10, add. Next ADDIWB.
  - ADDIWB: regdst=0, memtoreg=0, regwrite=1. Next FETCH.
  - JEX: pcsrc=10, pcen=1. Next FETCH.
- pcen = pcwrite | (beq_state & zero) | (bne_state & ~zero).
- funct decode (RTYPEEX only): 100000→010, 100010→110, 100100→000, 100101→001, 101010→111. Any other funct→010 (add); no trap.
- Latency with memready held at 1:
  - lw 5 cycles; sw, R-type, addi 4 cycles; beq, bne, j 3 cycles.
  - Each memready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- regwrite and memwrite are never both 1.
- irwrite=1 only in FETCH.

Test Plan:
- Reset then run: hold reset for 2 edges, then release with memready=1 → state=0 on the first edge. The FETCH outputs are alusrcb=01, irwrite=1, pcen=1. With reset high, pcen=irwrite=0.
- lw sequence: op=100011, memready=1 → states 0,1,2,3,4,0. In state 4: regwrite=1, memtoreg=1, regdst=0.
- sw with wait: op=101011, memready=0 for 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles at iord=1, then state 0.
- R-type slt: op=000000, funct=101010 → alucontrol=111 in state 6. In state 7: regwrite=1, regdst=1.
- beq/bne: op=000100 with zero=1 → pcen=1, pcsrc=01. The same with zero=0 → pcen=0. op=000101 with zero=0 → pcen=1.
- Illegal/reset mid-op: op=111111 → illegal_op=1 for one cycle in DECODE, then FETCH, and regwrite/memwrite never asserted. Assert reset in MEMWR → memwrite drops to 0 combinationally and the state is 0 on the next edge.

Source files
------------

// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//
// Control FSM for the shared multicycle MIPS datapath (unified instruction/
// data memory, single ALU, register file, IR and PC). Every cycle it looks at
// the current state plus the IR fields and drives the datapath mux selects,
// write enables and ALU control.
//
// Handshake: the memory has no request/accept split. The FSM presents an
// address (iord) and, for stores, a write strobe; the access completes on the
// rising edge where memready=1. FETCH, MEMRD and MEMWR hold, with outputs
// unchanged, until that edge.
//
// Ports:
//   clk, reset    - rising-edge clock, synchronous active-high reset
//   op, funct     - IR[31:26] and IR[5:0]
//   zero          - ALU zero flag (branch compare)
//   memready      - memory completes its access this cycle
//   iord          - memory address select: 0=PC, 1=ALUOut
//   memwrite      - memory write strobe
//   irwrite       - IR load enable
//   regdst        - register write address: 0=rt, 1=rd
//   memtoreg      - register write data: 0=ALUOut, 1=MDR
//   regwrite      - register file write enable
//   alusrca       - ALU A: 0=PC, 1=rs
//   alusrcb       - ALU B: 00=rt, 01=4, 10=signimm, 11=signimm<<2
//   pcsrc         - PC source: 00=ALU result, 01=ALUOut, 10=jump target
//   pcen          - PC load enable
//   alucontrol    - 010 add, 110 sub, 000 and, 001 or, 111 slt
//   illegal_op    - pulse in DECODE when the opcode is not supported
//   state         - current FSM state, for debug and checkers
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
   parameter int SUPPORT_BNE = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       memready,
   output logic       iord,
   output logic       memwrite,
   output logic       irwrite,
   output logic       regdst,
   output logic       memtoreg,
   output logic       regwrite,
   output logic       alusrca,
   output logic [1:0] alusrcb,
   output logic [1:0] pcsrc,
   output logic       pcen,
   output logic [2:0] alucontrol,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_BNEEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   // Per-state control word. Fields that depend only on the state are held
   // in a register; memready/zero/funct/op qualifications are applied on
   // the output side so they act within the same cycle.
   typedef struct packed {
      logic       iord;
      logic       memwrite;
      logic       fetch;      // irwrite and pcwrite follow memready
      logic       regdst;
      logic       memtoreg;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] alu_base;   // ALU op when not decoding funct
      logic       alu_funct;  // ALU op taken from funct
      logic       beq;        // PC loads when zero=1
      logic       bne;        // PC loads when zero=0
      logic       jump;       // unconditional PC load
   } ctrl_t;

   function automatic ctrl_t decode_state(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.fetch    = 1'b1;
            c.alusrcb  = 2'b01;
            c.alu_base = ALU_ADD;
         end
         S_DECODE: begin
            c.alusrcb  = 2'b11;
            c.alu_base = ALU_ADD;
         end
         S_MEMADR: begin
            c.alusrca  = 1'b1;
            c.alusrcb  = 2'b10;
            c.alu_base = ALU_ADD;
         end
         S_MEMRD: begin
            c.iord = 1'b1;
         end
         S_MEMWB: begin
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
         end
         S_MEMWR: begin
            c.iord     = 1'b1;
            c.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            c.alusrca   = 1'b1;
            c.alu_funct = 1'b1;
         end
         S_RTYPEWB: begin
            c.regdst   = 1'b1;
            c.regwrite = 1'b1;
         end
         S_BEQEX: begin
            c.alusrca  = 1'b1;
            c.alu_base = ALU_SUB;
            c.pcsrc    = 2'b01;
            c.beq      = 1'b1;
         end
         S_BNEEX: begin
            c.alusrca  = 1'b1;
            c.alu_base = ALU_SUB;
            c.pcsrc    = 2'b01;
            c.bne      = 1'b1;
         end
         S_ADDIEX: begin
            c.alusrca  = 1'b1;
            c.alusrcb  = 2'b10;
            c.alu_base = ALU_ADD;
         end
         S_ADDIWB: begin
            c.regwrite = 1'b1;
         end
         S_JEX: begin
            c.pcsrc = 2'b10;
            c.jump  = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   state_t state_q, state_d;
   ctrl_t  ctrl_q, ctrl_d;
   logic   op_legal;
   logic [2:0] funct_alu;

   // Opcodes this controller knows how to sequence.
   always_comb begin
      op_legal = 1'b0;
      case (op)
         OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: op_legal = 1'b1;
         OP_BNE:                                        op_legal = (SUPPORT_BNE != 0);
         default:                                       op_legal = 1'b0;
      endcase
   end

   // Unknown funct codes quietly execute as add rather than trapping.
   always_comb begin
      funct_alu = ALU_ADD;
      case (funct)
         6'b100000: funct_alu = ALU_ADD;
         6'b100010: funct_alu = ALU_SUB;
         6'b100100: funct_alu = ALU_AND;
         6'b100101: funct_alu = ALU_OR;
         6'b101010: funct_alu = ALU_SLT;
         default:   funct_alu = ALU_ADD;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:   state_d = memready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            state_d = S_FETCH;
            if (op_legal) begin
               case (op)
                  OP_LW, OP_SW: state_d = S_MEMADR;
                  OP_RTYPE:     state_d = S_RTYPEEX;
                  OP_BEQ:       state_d = S_BEQEX;
                  OP_BNE:       state_d = S_BNEEX;
                  OP_ADDI:      state_d = S_ADDIEX;
                  OP_J:         state_d = S_JEX;
                  default:      state_d = S_FETCH;
               endcase
            end
         end
         S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = memready ? S_MEMWB : S_MEMRD;
         S_MEMWB:   state_d = S_FETCH;
         S_MEMWR:   state_d = memready ? S_FETCH : S_MEMWR;
         S_RTYPEEX: state_d = S_RTYPEWB;
         S_RTYPEWB: state_d = S_FETCH;
         S_BEQEX:   state_d = S_FETCH;
         S_BNEEX:   state_d = S_FETCH;
         S_ADDIEX:  state_d = S_ADDIWB;
         S_ADDIWB:  state_d = S_FETCH;
         S_JEX:     state_d = S_FETCH;
         default:   state_d = S_FETCH;
      endcase
      ctrl_d = decode_state(state_d);
   end

   // The control word register always tracks decode_state(state_q).
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= decode_state(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   // Architectural strobes are blanked the moment reset rises so an
   // in-flight store or register write cannot land.
   assign iord       = ctrl_q.iord;
   assign memwrite   = ~reset & ctrl_q.memwrite;
   assign irwrite    = ~reset & ctrl_q.fetch & memready;
   assign regdst     = ctrl_q.regdst;
   assign memtoreg   = ctrl_q.memtoreg;
   assign regwrite   = ~reset & ctrl_q.regwrite;
   assign alusrca    = ctrl_q.alusrca;
   assign alusrcb    = ctrl_q.alusrcb;
   assign pcsrc      = ctrl_q.pcsrc;
   assign pcen       = ~reset & ((ctrl_q.fetch & memready) | ctrl_q.jump |
                                 (ctrl_q.beq & zero) | (ctrl_q.bne & ~zero));
   assign alucontrol = ctrl_q.alu_funct ? funct_alu : ctrl_q.alu_base;
   assign illegal_op = (state_q == S_DECODE) & ~op_legal;
   assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//
// Directed sequences of instructions. Each cycle the bench states which FSM
// state it expects, builds the full expected output word from a table of the
// per-state control outputs, queues it, and compares it against the DUT on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

   logic       clk;
   logic       reset;
   logic [5:0] op;
   logic [5:0] funct;
   logic       zero;
   logic       memready;
   logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
   logic [1:0] alusrcb, pcsrc;
   logic       pcen;
   logic [2:0] alucontrol;
   logic       illegal_op;
   logic [3:0] state;

   int tests_run = 0;
   int tests_failed = 0;
   int mw_cycles = 0;

   logic [19:0] exp_q[$];

   mips_multicycle_ctrl #(.SUPPORT_BNE(1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
      .memready(memready), .iord(iord), .memwrite(memwrite),
      .irwrite(irwrite), .regdst(regdst), .memtoreg(memtoreg),
      .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb),
      .pcsrc(pcsrc), .pcen(pcen), .alucontrol(alucontrol),
      .illegal_op(illegal_op), .state(state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for a given state and input set, straight from the
   // per-state output table.
   // Packing: {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
   //           alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op}
   function automatic logic [19:0] model(input logic [3:0] st, input logic rst,
                                         input logic [5:0] o, input logic [5:0] f,
                                         input logic z, input logic mr);
      logic i_d, mw, irw, rd, m2r, rw, asa, pe, ill;
      logic [1:0] asb, pcs;
      logic [2:0] alu;
      i_d = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; asa = 0; pe = 0; ill = 0;
      asb = 2'b00; pcs = 2'b00; alu = 3'b000;
      case (st)
         4'd0:  begin asb = 2'b01; alu = 3'b010; irw = mr; pe = mr; end
         4'd1:  begin
            asb = 2'b11; alu = 3'b010;
            ill = !(o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                    o == 6'b000100 || o == 6'b000101 || o == 6'b001000 ||
                    o == 6'b000010);
         end
         4'd2:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
         4'd3:  begin i_d = 1; end
         4'd4:  begin m2r = 1; rw = 1; end
         4'd5:  begin i_d = 1; mw = 1; end
         4'd6:  begin
            asa = 1;
            case (f)
               6'b100010: alu = 3'b110;
               6'b100100: alu = 3'b000;
               6'b100101: alu = 3'b001;
               6'b101010: alu = 3'b111;
               default:   alu = 3'b010;
            endcase
         end
         4'd7:  begin rd = 1; rw = 1; end
         4'd8:  begin asa = 1; alu = 3'b110; pcs = 2'b01; pe = z; end
         4'd12: begin asa = 1; alu = 3'b110; pcs = 2'b01; pe = ~z; end
         4'd9:  begin asa = 1; asb = 2'b10; alu = 3'b010; end
         4'd10: begin rw = 1; end
         4'd11: begin pcs = 2'b10; pe = 1; end
         default: ;
      endcase
      if (rst) begin
         mw = 0; rw = 0; irw = 0; pe = 0;
      end
      return {st, i_d, mw, irw, rd, m2r, rw, asa, asb, pcs, pe, alu, ill};
   endfunction

   // scoreboard compare
   task automatic check(input string tag);
      logic [19:0] obs;
      logic [19:0] exp;
      obs = {state, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
             alusrca, alusrcb, pcsrc, pcen, alucontrol, illegal_op};
      tests_run++;
      if (exp_q.size() == 0) begin
         tests_failed++;
         $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
      end else begin
         exp = exp_q.pop_front();
         assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
         end
      end
      tests_run++;
      assert ((regwrite & memwrite) === 1'b0) else begin
         tests_failed++;
         $error("FAIL %s_rw_mw_excl: observed %b%b expected not both 1", tag, regwrite, memwrite);
      end
      if (memwrite === 1'b1) mw_cycles++;
   endtask

   // driver: one clock cycle of stimulus plus the state expected during it
   task automatic cyc(input string tag, input logic rst, input logic [5:0] o,
                      input logic [5:0] f, input logic z, input logic mr,
                      input logic [3:0] st);
      reset = rst; op = o; funct = f; zero = z; memready = mr;
      exp_q.push_back(model(st, rst, o, f, z, mr));
      @(negedge clk);
      check(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0; memready = 1'b1;
      @(posedge clk);
      #1;
      // second reset edge: state already FETCH, strobes blanked
      cyc("reset_hold", 1, 6'b000000, 6'd0, 0, 1, 4'd0);
      cyc("reset_rel",  0, 6'b000000, 6'd0, 0, 1, 4'd0);
      cyc("nop_dec",    0, 6'b000000, 6'd0, 0, 1, 4'd1);
      cyc("nop_ex",     0, 6'b000000, 6'd0, 0, 1, 4'd6);
      cyc("nop_wb",     0, 6'b000000, 6'd0, 0, 1, 4'd7);

      // lw, no waits
      cyc("lw_f",   0, 6'b100011, 6'd0, 0, 1, 4'd0);
      cyc("lw_d",   0, 6'b100011, 6'd0, 0, 1, 4'd1);
      cyc("lw_adr", 0, 6'b100011, 6'd0, 0, 1, 4'd2);
      cyc("lw_rd",  0, 6'b100011, 6'd0, 0, 1, 4'd3);
      cyc("lw_wb",  0, 6'b100011, 6'd0, 0, 1, 4'd4);

      // lw with a fetch wait and a read wait
      cyc("lww_f0", 0, 6'b100011, 6'd0, 0, 0, 4'd0);
      cyc("lww_f1", 0, 6'b100011, 6'd0, 0, 1, 4'd0);
      cyc("lww_d",  0, 6'b100011, 6'd0, 0, 1, 4'd1);
      cyc("lww_a",  0, 6'b100011, 6'd0, 0, 0, 4'd2);
      cyc("lww_r0", 0, 6'b100011, 6'd0, 0, 0, 4'd3);
      cyc("lww_r1", 0, 6'b100011, 6'd0, 0, 1, 4'd3);
      cyc("lww_wb", 0, 6'b100011, 6'd0, 0, 1, 4'd4);

      // sw with three wait cycles in MEMWR
      cyc("sw_f",   0, 6'b101011, 6'd0, 0, 1, 4'd0);
      cyc("sw_d",   0, 6'b101011, 6'd0, 0, 1, 4'd1);
      cyc("sw_a",   0, 6'b101011, 6'd0, 0, 1, 4'd2);
      mw_cycles = 0;
      cyc("sw_w0",  0, 6'b101011, 6'd0, 0, 0, 4'd5);
      cyc("sw_w1",  0, 6'b101011, 6'd0, 0, 0, 4'd5);
      cyc("sw_w2",  0, 6'b101011, 6'd0, 0, 0, 4'd5);
      cyc("sw_w3",  0, 6'b101011, 6'd0, 0, 1, 4'd5);
      tests_run++;
      assert (mw_cycles === 4) else begin
         tests_failed++;
         $error("FAIL sw_mw_run: observed %0d expected 4", mw_cycles);
      end

      // R-type: slt, sub, unknown funct
      cyc("slt_f",  0, 6'b000000, 6'b101010, 0, 1, 4'd0);
      cyc("slt_d",  0, 6'b000000, 6'b101010, 0, 1, 4'd1);
      cyc("slt_ex", 0, 6'b000000, 6'b101010, 0, 1, 4'd6);
      cyc("slt_wb", 0, 6'b000000, 6'b101010, 0, 1, 4'd7);
      cyc("sub_f",  0, 6'b000000, 6'b100010, 0, 1, 4'd0);
      cyc("sub_d",  0, 6'b000000, 6'b100010, 0, 1, 4'd1);
      cyc("sub_ex", 0, 6'b000000, 6'b100010, 0, 1, 4'd6);
      cyc("sub_wb", 0, 6'b000000, 6'b100010, 0, 1, 4'd7);
      cyc("or_f",   0, 6'b000000, 6'b100101, 0, 1, 4'd0);
      cyc("or_d",   0, 6'b000000, 6'b100101, 0, 1, 4'd1);
      cyc("or_ex",  0, 6'b000000, 6'b100101, 0, 1, 4'd6);
      cyc("or_wb",  0, 6'b000000, 6'b100101, 0, 1, 4'd7);
      cyc("unk_f",  0, 6'b000000, 6'b111111, 0, 1, 4'd0);
      cyc("unk_d",  0, 6'b000000, 6'b111111, 0, 1, 4'd1);
      cyc("unk_ex", 0, 6'b000000, 6'b111111, 0, 1, 4'd6);
      cyc("unk_wb", 0, 6'b000000, 6'b111111, 0, 1, 4'd7);

      // beq taken / not taken, bne taken / not taken
      cyc("beq1_f", 0, 6'b000100, 6'd0, 1, 1, 4'd0);
      cyc("beq1_d", 0, 6'b000100, 6'd0, 1, 1, 4'd1);
      cyc("beq1_x", 0, 6'b000100, 6'd0, 1, 1, 4'd8);
      cyc("beq0_f", 0, 6'b000100, 6'd0, 0, 1, 4'd0);
      cyc("beq0_d", 0, 6'b000100, 6'd0, 0, 1, 4'd1);
      cyc("beq0_x", 0, 6'b000100, 6'd0, 0, 1, 4'd8);
      cyc("bne0_f", 0, 6'b000101, 6'd0, 0, 1, 4'd0);
      cyc("bne0_d", 0, 6'b000101, 6'd0, 0, 1, 4'd1);
      cyc("bne0_x", 0, 6'b000101, 6'd0, 0, 1, 4'd12);
      cyc("bne1_f", 0, 6'b000101, 6'd0, 1, 1, 4'd0);
      cyc("bne1_d", 0, 6'b000101, 6'd0, 1, 1, 4'd1);
      cyc("bne1_x", 0, 6'b000101, 6'd0, 1, 1, 4'd12);

      // addi and j
      cyc("addi_f",  0, 6'b001000, 6'd0, 0, 1, 4'd0);
      cyc("addi_d",  0, 6'b001000, 6'd0, 0, 1, 4'd1);
      cyc("addi_ex", 0, 6'b001000, 6'd0, 0, 1, 4'd9);
      cyc("addi_wb", 0, 6'b001000, 6'd0, 0, 1, 4'd10);
      cyc("j_f",     0, 6'b000010, 6'd0, 0, 1, 4'd0);
      cyc("j_d",     0, 6'b000010, 6'd0, 0, 1, 4'd1);
      cyc("j_ex",    0, 6'b000010, 6'd0, 0, 1, 4'd11);

      // illegal opcode: one-cycle pulse in DECODE, straight back to FETCH
      cyc("ill_f",  0, 6'b111111, 6'd0, 0, 1, 4'd0);
      cyc("ill_d",  0, 6'b111111, 6'd0, 0, 1, 4'd1);
      cyc("ill_f2", 0, 6'b111111, 6'd0, 0, 0, 4'd0);

      // reset while a store is waiting in MEMWR
      cyc("rsw_f",  0, 6'b101011, 6'd0, 0, 1, 4'd0);
      cyc("rsw_d",  0, 6'b101011, 6'd0, 0, 1, 4'd1);
      cyc("rsw_a",  0, 6'b101011, 6'd0, 0, 1, 4'd2);
      cyc("rsw_w",  0, 6'b101011, 6'd0, 0, 0, 4'd5);
      cyc("rsw_rst", 1, 6'b101011, 6'd0, 0, 0, 4'd5);
      cyc("rsw_post", 0, 6'b101011, 6'd0, 0, 1, 4'd0);
      cyc("rsw_dec",  0, 6'b101011, 6'd0, 0, 1, 4'd1);

      tests_run++;
      assert (exp_q.size() === 0) else begin
         tests_failed++;
         $error("FAIL sb_drain: observed %0d left expected 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
